// File: rtl/frotaegis_pkg.sv
// Shared types and default parameters for the Fortaegis entropy-collection controller.
package frotaegis_pkg;

    localparam int WORD_W_DEF     = 32;
    localparam int COLL_WORDS_DEF = 16;
    localparam int RCT_LIMIT_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/frotaegis_if.sv
// Downstream word handshake: assembled word plus valid/ready.
interface frotaegis_if
    import frotaegis_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();

    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/frotaegis_rct.sv
// Repetition-count tester; only compiled when FROTAEGIS_HEALTH_EN is defined.
`ifdef FROTAEGIS_HEALTH_EN
module frotaegis_rct
    import frotaegis_pkg::*;
#(
    parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
    input  logic clk200,
    input  logic rstn,
    input  logic clear,
    input  logic sample_en,
    input  logic bit_in,
    output logic fail
);

    localparam int CW = $clog2(RCT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(RCT_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d, run_len;
    logic          last_q, last_d;

    // Run length saturates at the limit so the counter can never wrap.
    always_comb begin
        run_len = CW'(1);
        if (cnt_q != '0 && bit_in == last_q) begin
            run_len = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
        end
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clear) begin
            cnt_d = '0;
        end else if (sample_en) begin
            cnt_d  = run_len;
            last_d = bit_in;
        end
    end

    assign fail = sample_en & ~clear & (run_len == LIMIT);

    always_ff @(posedge clk200) begin
        if (rstn) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule
`endif

// File: rtl/frotaegis_top.sv
// Entropy-collection controller: shifts raw bits into words and hands them downstream.
// Optional repetition-count health test enabled by FROTAEGIS_HEALTH_EN.
module frotaegis_top
    import frotaegis_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int COLL_WORDS = COLL_WORDS_DEF,
    parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
    input  logic        clk200,
    input  logic        rstn,
    input  logic        StartColl,
    input  logic        ent_bit,
    frotaegis_if.master dbus,
    output logic        Collect,
    output logic        done,
    output logic        health_fail
);

    localparam int BW  = $clog2(WORD_W);
    localparam int WCW = $clog2(COLL_WORDS) + 1;
    localparam logic [BW-1:0]  BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(COLL_WORDS - 1);

    if (WORD_W < 2 || COLL_WORDS < 1 || RCT_LIMIT < 2) begin : g_bad_param
        $error("frotaegis_top: parameter out of range");
    end

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              rise, sess_start, bit_last, last_word, hs, abort;
    logic              rct_fail, health_fail_s;

    assign rise       = StartColl & ~start_q;
    assign sess_start = (state_q == IDLE) & rise & ~health_fail_s;
    assign bit_last   = (bit_cnt_q == BIT_LAST);
    assign last_word  = (word_cnt_q == WORD_LAST);
    assign hs         = data_valid_q & dbus.data_ready;
    assign abort      = ((state_q == COLLECT) | (state_q == HOLD)) & (~StartColl | rct_fail);

`ifdef FROTAEGIS_HEALTH_EN
    logic health_fail_q, health_fail_d;

    frotaegis_rct #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
        .clk200    (clk200),
        .rstn      (rstn),
        .clear     (sess_start),
        .sample_en (state_q == COLLECT),
        .bit_in    (ent_bit),
        .fail      (rct_fail)
    );

    assign health_fail_d = health_fail_q | rct_fail;

    always_ff @(posedge clk200) begin
        if (rstn) health_fail_q <= 1'b0;
        else      health_fail_q <= health_fail_d;
    end

    assign health_fail_s = health_fail_q;
`else
    assign rct_fail      = 1'b0;
    assign health_fail_s = 1'b0;
`endif

    assign health_fail     = health_fail_s;
    assign dbus.data_out   = data_out_q;
    assign dbus.data_valid = data_valid_q;

    always_ff @(posedge clk200) begin
        if (rstn) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Abort wins over completion and over a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sess_start) state_d = COLLECT;
            COLLECT: if (abort) state_d = IDLE;
                     else if (bit_last) state_d = HOLD;
            HOLD:    if (abort) state_d = IDLE;
                     else if (hs) state_d = last_word ? DONE : COLLECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Collect = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            COLLECT, HOLD: Collect = 1'b1;
            DONE:          done    = 1'b1;
            default:       ;
        endcase
    end

    always_comb begin
        start_d      = StartColl;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        unique case (state_q)
            IDLE: begin
                if (sess_start) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    shreg_d    = '0;
                end
            end
            COLLECT: begin
                shreg_d   = {shreg_q[WORD_W-2:0], ent_bit};
                bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
                if (bit_last && !abort) begin
                    data_out_d   = shreg_d;
                    data_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    data_valid_d = 1'b0;
                end else if (hs) begin
                    data_valid_d = 1'b0;
                    if (!last_word) word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk200) begin
        if (rstn) begin
            start_q      <= 1'b1;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            start_q      <= start_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

endmodule

// File: tb/tb_frotaegis_top.sv
// Directed bench for frotaegis_top with WORD_W=8, COLL_WORDS=2, RCT_LIMIT=16.
module tb_frotaegis_top;

    logic clk200     = 1'b0;
    logic rstn       = 1'b1;
    logic start_coll = 1'b0;
    logic ent_bit    = 1'b0;
    logic collect, done, health_fail;
    int   pass_cnt   = 0;
    int   tot_cnt    = 0;

    frotaegis_if #(.WORD_W(8)) dbus ();

    frotaegis_top #(.WORD_W(8), .COLL_WORDS(2), .RCT_LIMIT(16)) dut (
        .clk200      (clk200),
        .rstn        (rstn),
        .StartColl   (start_coll),
        .ent_bit     (ent_bit),
        .dbus        (dbus),
        .Collect     (collect),
        .done        (done),
        .health_fail (health_fail)
    );

    always #5 clk200 = ~clk200;

    task automatic tick();
        @(posedge clk200);
        #1;
    endtask

    task automatic feed(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            ent_bit = w[i];
            tick();
        end
    endtask

    task automatic begin_session();
        start_coll = 1'b0;
        tick();
        start_coll = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b1; start_coll = 1'b1; dbus.data_ready = 1'b1; ent_bit = 1'b0;
        tick(); tick();
        tot_cnt++; if (collect !== 1'b0) $display("FAIL rst_collect: got %b exp 0", collect); else pass_cnt++;
        tot_cnt++; if (dbus.data_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", dbus.data_valid); else pass_cnt++;
        tot_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else pass_cnt++;
        tot_cnt++; if (health_fail !== 1'b0) $display("FAIL rst_health: got %b exp 0", health_fail); else pass_cnt++;
        tot_cnt++; if (dbus.data_out !== 8'h00) $display("FAIL rst_data: got %h exp 00", dbus.data_out); else pass_cnt++;
        rstn = 1'b0;
        repeat (4) tick();
        tot_cnt++; if (collect !== 1'b0) $display("FAIL held_start_no_session: got %b exp 0", collect); else pass_cnt++;
        begin_session();
        tot_cnt++; if (collect !== 1'b1) $display("FAIL start_after_fall: got %b exp 1", collect); else pass_cnt++;
        start_coll = 1'b0;
        tick();
        tot_cnt++; if (collect !== 1'b0) $display("FAIL abort_to_idle: got %b exp 0", collect); else pass_cnt++;
    endtask

    task automatic test_basic();
        begin_session();
        tot_cnt++; if (collect !== 1'b1) $display("FAIL basic_collect: got %b exp 1", collect); else pass_cnt++;
        feed(8'hB2);
        tot_cnt++; if (dbus.data_valid !== 1'b1) $display("FAIL basic_valid0: got %b exp 1", dbus.data_valid); else pass_cnt++;
        tot_cnt++; if (dbus.data_out !== 8'hB2) $display("FAIL basic_word0: got %h exp b2", dbus.data_out); else pass_cnt++;
        tick();
        tot_cnt++; if (dbus.data_valid !== 1'b0) $display("FAIL basic_one_valid_cycle: got %b exp 0", dbus.data_valid); else pass_cnt++;
        tot_cnt++; if (done !== 1'b0) $display("FAIL basic_early_done: got %b exp 0", done); else pass_cnt++;
        feed(8'hF0);
        tot_cnt++; if (dbus.data_valid !== 1'b1) $display("FAIL basic_valid1: got %b exp 1", dbus.data_valid); else pass_cnt++;
        tot_cnt++; if (dbus.data_out !== 8'hF0) $display("FAIL basic_word1: got %h exp f0", dbus.data_out); else pass_cnt++;
        tick();
        tot_cnt++; if (done !== 1'b1) $display("FAIL basic_done_edge19: got %b exp 1", done); else pass_cnt++;
        tot_cnt++; if (collect !== 1'b0) $display("FAIL basic_collect_end: got %b exp 0", collect); else pass_cnt++;
        tot_cnt++; if (dbus.data_valid !== 1'b0) $display("FAIL basic_valid_end: got %b exp 0", dbus.data_valid); else pass_cnt++;
        tick();
        tot_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b exp 0", done); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        begin_session();
        feed(8'hB2);
        dbus.data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ent_bit = i[0];
            tick();
            tot_cnt++;
            if (dbus.data_valid !== 1'b1 || dbus.data_out !== 8'hB2)
                $display("FAIL bp_stall_hold: got valid=%b data=%h exp valid=1 data=b2", dbus.data_valid, dbus.data_out);
            else pass_cnt++;
        end
        dbus.data_ready = 1'b1;
        tick();
        tot_cnt++; if (dbus.data_valid !== 1'b0) $display("FAIL bp_accept: got %b exp 0", dbus.data_valid); else pass_cnt++;
        for (int i = 7; i >= 1; i--) begin
            ent_bit = (i >= 4);
            tick();
        end
        tot_cnt++; if (dbus.data_valid !== 1'b0) $display("FAIL bp_no_stall_sampling: got %b exp 0", dbus.data_valid); else pass_cnt++;
        ent_bit = 1'b0;
        tick();
        tot_cnt++; if (dbus.data_out !== 8'hF0 || dbus.data_valid !== 1'b1)
            $display("FAIL bp_word1: got valid=%b data=%h exp valid=1 data=f0", dbus.data_valid, dbus.data_out); else pass_cnt++;
        tick();
        tot_cnt++; if (done !== 1'b1) $display("FAIL bp_done: got %b exp 1", done); else pass_cnt++;
        tick();
    endtask

    task automatic test_abort();
        logic saw_done;
        begin_session();
        feed(8'hB2);
        tick();
        ent_bit = 1'b1; tick(); tick(); tick();
        start_coll = 1'b0;
        tick();
        saw_done = done;
        tot_cnt++; if (collect !== 1'b0) $display("FAIL abort_collect: got %b exp 0", collect); else pass_cnt++;
        tot_cnt++; if (dbus.data_valid !== 1'b0) $display("FAIL abort_valid: got %b exp 0", dbus.data_valid); else pass_cnt++;
        tick(); saw_done = saw_done | done;
        tick(); saw_done = saw_done | done;
        tot_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b exp 0", saw_done); else pass_cnt++;
        begin_session();
        tot_cnt++; if (collect !== 1'b1) $display("FAIL abort_restart: got %b exp 1", collect); else pass_cnt++;
        feed(8'h5A);
        tot_cnt++; if (dbus.data_out !== 8'h5A || dbus.data_valid !== 1'b1)
            $display("FAIL abort_fresh_word: got valid=%b data=%h exp valid=1 data=5a", dbus.data_valid, dbus.data_out); else pass_cnt++;
        start_coll = 1'b0;
        tick();
        tot_cnt++; if (collect !== 1'b0 || dbus.data_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_over_handshake: got collect=%b valid=%b done=%b exp 0 0 0", collect, dbus.data_valid, done); else pass_cnt++;
    endtask

    task automatic test_health();
        ent_bit = 1'b1;
        begin_session();
        repeat (8) tick();
        tot_cnt++; if (dbus.data_out !== 8'hFF || dbus.data_valid !== 1'b1)
            $display("FAIL hc_word0: got valid=%b data=%h exp valid=1 data=ff", dbus.data_valid, dbus.data_out); else pass_cnt++;
        tick();
        repeat (7) tick();
        tot_cnt++; if (health_fail !== 1'b0 || collect !== 1'b1)
            $display("FAIL hc_15_samples: got hf=%b collect=%b exp hf=0 collect=1", health_fail, collect); else pass_cnt++;
        tick();
`ifdef FROTAEGIS_HEALTH_EN
        tot_cnt++; if (health_fail !== 1'b1) $display("FAIL hc_fail_set: got %b exp 1", health_fail); else pass_cnt++;
        tot_cnt++; if (collect !== 1'b0 || dbus.data_valid !== 1'b0)
            $display("FAIL hc_session_abort: got collect=%b valid=%b exp 0 0", collect, dbus.data_valid); else pass_cnt++;
        begin_session();
        tot_cnt++; if (collect !== 1'b0 || health_fail !== 1'b1)
            $display("FAIL hc_rise_ignored: got collect=%b hf=%b exp collect=0 hf=1", collect, health_fail); else pass_cnt++;
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        tick();
        tot_cnt++; if (health_fail !== 1'b0) $display("FAIL hc_clear_on_reset: got %b exp 0", health_fail); else pass_cnt++;
        begin_session();
        tot_cnt++; if (collect !== 1'b1) $display("FAIL hc_session_after_reset: got %b exp 1", collect); else pass_cnt++;
        start_coll = 1'b0;
        tick();
`else
        tot_cnt++; if (dbus.data_out !== 8'hFF || dbus.data_valid !== 1'b1)
            $display("FAIL hc_word1: got valid=%b data=%h exp valid=1 data=ff", dbus.data_valid, dbus.data_out); else pass_cnt++;
        tot_cnt++; if (health_fail !== 1'b0) $display("FAIL hc_flag_off: got %b exp 0", health_fail); else pass_cnt++;
        tick();
        tot_cnt++; if (done !== 1'b1 || health_fail !== 1'b0)
            $display("FAIL hc_done: got done=%b hf=%b exp done=1 hf=0", done, health_fail); else pass_cnt++;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_health();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
